// File: rtl/rsa_key_bank_if.sv
// Load and read bus of rsa_key_bank.
// The master modport drives loads and read addresses; the slave modport is the key bank.
interface rsa_key_bank_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned WORDS  = 2,
    parameter int unsigned SLOTS  = 4
);
    localparam int unsigned OP_W = WORD_W * WORDS;
    localparam int unsigned SW   = $clog2(SLOTS);

    logic              ld_start;
    logic [SW-1:0]     ld_slot;
    logic              ld_valid;
    logic [WORD_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_done;
    logic              err;
    logic [SW-1:0]     rd_slot;
    logic              rd_valid;
    logic [OP_W-1:0]   primeNum;
    logic [OP_W-1:0]   privateKey;
    logic [OP_W-1:0]   cipher;

    modport master (
        output ld_start, ld_slot, ld_valid, ld_data, rd_slot,
        input  ld_ready, ld_busy, ld_done, err, rd_valid, primeNum, privateKey, cipher
    );

    modport slave (
        input  ld_start, ld_slot, ld_valid, ld_data, rd_slot,
        output ld_ready, ld_busy, ld_done, err, rd_valid, primeNum, privateKey, cipher
    );
endinterface

// File: rtl/rsa_key_bank.sv
// Multi-slot RSA key store: word-serial loader into shadow registers, atomic commit, registered
// read port. Define RSA_KEY_BANK_ZEROIZE_EN to add a synchronous zeroize input.
module rsa_key_bank #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned WORDS  = 2,
    parameter int unsigned SLOTS  = 4
) (
    input logic clk,
    input logic rst_n,
`ifdef RSA_KEY_BANK_ZEROIZE_EN
    input logic zeroize,
`endif
    rsa_key_bank_if.slave bus
);
    localparam int unsigned OP_W = WORD_W * WORDS;
    localparam int unsigned SW   = $clog2(SLOTS);
    localparam int unsigned CW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {StIdle, StLoadN, StLoadD, StLoadC, StCommit} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [OP_W-1:0]   sh_n_q, sh_n_d, sh_d_q, sh_d_d, sh_c_q, sh_c_d;
    logic [OP_W-1:0]   st_n_q [SLOTS];
    logic [OP_W-1:0]   st_d_q [SLOTS];
    logic [OP_W-1:0]   st_c_q [SLOTS];
    logic [SLOTS-1:0]  valid_q;
    logic              done_q, err_q, rd_valid_q;
    logic [OP_W-1:0]   rd_n_q, rd_d_q, rd_c_q;
    logic              zero_w, ready_w, busy_w, xfer_w, last_w, start_w, commit_w;

`ifdef RSA_KEY_BANK_ZEROIZE_EN
    assign zero_w = zeroize;
`else
    assign zero_w = 1'b0;
`endif

    assign xfer_w   = bus.ld_valid & ready_w;
    assign last_w   = (cnt_q == CW'(WORDS - 1));
    assign start_w  = bus.ld_start & (state_q == StIdle);
    assign commit_w = (state_q == StCommit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.ld_start) state_d = StLoadN;
            StLoadN:  if (xfer_w && last_w) state_d = StLoadD;
            StLoadD:  if (xfer_w && last_w) state_d = StLoadC;
            StLoadC:  if (xfer_w && last_w) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (zero_w) state_d = StIdle;
    end

    always_comb begin
        ready_w = 1'b0;
        busy_w  = 1'b1;
        unique case (state_q)
            StIdle:                    busy_w  = 1'b0;
            StLoadN, StLoadD, StLoadC: ready_w = 1'b1;
            default:                   ;
        endcase
    end

    // Loader datapath: shadows stay private until the commit edge.
    always_comb begin
        cnt_d  = cnt_q;
        slot_d = slot_q;
        sh_n_d = sh_n_q;
        sh_d_d = sh_d_q;
        sh_c_d = sh_c_q;
        if (start_w) begin
            slot_d = bus.ld_slot;
            cnt_d  = '0;
            sh_n_d = '0;
            sh_d_d = '0;
            sh_c_d = '0;
        end else if (xfer_w) begin
            cnt_d = last_w ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                StLoadN: sh_n_d[int'(cnt_q)*WORD_W +: WORD_W] = bus.ld_data;
                StLoadD: sh_d_d[int'(cnt_q)*WORD_W +: WORD_W] = bus.ld_data;
                StLoadC: sh_c_d[int'(cnt_q)*WORD_W +: WORD_W] = bus.ld_data;
                default: ;
            endcase
        end
        if (zero_w) begin
            cnt_d  = '0;
            slot_d = '0;
            sh_n_d = '0;
            sh_d_d = '0;
            sh_c_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            slot_q <= '0;
            sh_n_q <= '0;
            sh_d_q <= '0;
            sh_c_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            sh_n_q <= sh_n_d;
            sh_d_q <= sh_d_d;
            sh_c_q <= sh_c_d;
        end
    end

    // Reads sample storage as it stood before the edge, so a commit is visible one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                st_n_q[i] <= '0;
                st_d_q[i] <= '0;
                st_c_q[i] <= '0;
            end
            valid_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_n_q     <= '0;
            rd_d_q     <= '0;
            rd_c_q     <= '0;
        end else if (zero_w) begin
            for (int i = 0; i < SLOTS; i++) begin
                st_n_q[i] <= '0;
                st_d_q[i] <= '0;
                st_c_q[i] <= '0;
            end
            valid_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_n_q     <= '0;
            rd_d_q     <= '0;
            rd_c_q     <= '0;
        end else begin
            rd_valid_q <= valid_q[bus.rd_slot];
            rd_n_q     <= valid_q[bus.rd_slot] ? st_n_q[bus.rd_slot] : '0;
            rd_d_q     <= valid_q[bus.rd_slot] ? st_d_q[bus.rd_slot] : '0;
            rd_c_q     <= valid_q[bus.rd_slot] ? st_c_q[bus.rd_slot] : '0;
            done_q     <= commit_w;
            err_q      <= bus.ld_start & busy_w;
            if (start_w) valid_q[bus.ld_slot] <= 1'b0;
            if (commit_w) begin
                st_n_q[slot_q]  <= sh_n_q;
                st_d_q[slot_q]  <= sh_d_q;
                st_c_q[slot_q]  <= sh_c_q;
                valid_q[slot_q] <= 1'b1;
            end
        end
    end

    assign bus.ld_ready   = ready_w;
    assign bus.ld_busy    = busy_w;
    assign bus.ld_done    = done_q;
    assign bus.err        = err_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.primeNum   = rd_n_q;
    assign bus.privateKey = rd_d_q;
    assign bus.cipher     = rd_c_q;
endmodule

// File: tb/tb_rsa_key_bank.sv
// Self-checking bench for rsa_key_bank: slot-level behavioural model compared every cycle,
// plus directed loads with literal expectations and a randomized traffic phase.
module tb_rsa_key_bank;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WORDS  = 2;
    localparam int unsigned SLOTS  = 4;
    localparam int unsigned OP_W   = WORD_W * WORDS;
    localparam int unsigned SW     = $clog2(SLOTS);
    localparam int unsigned NW     = 3 * WORDS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic zeroize = 1'b0;

    rsa_key_bank_if #(.WORD_W(WORD_W), .WORDS(WORDS), .SLOTS(SLOTS)) bus ();

    rsa_key_bank #(.WORD_W(WORD_W), .WORDS(WORDS), .SLOTS(SLOTS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef RSA_KEY_BANK_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int xfer_cnt = 0;

    // Model: a load is "busy" from the start edge; it collects NW words, then spends one
    // cycle committing. Each slot holds (n, d, c) plus a valid flag.
    bit              m_busy;
    int              m_cnt;
    int              m_slot;
    bit [WORD_W-1:0] m_w [NW];
    bit [OP_W-1:0]   m_n [SLOTS];
    bit [OP_W-1:0]   m_d [SLOTS];
    bit [OP_W-1:0]   m_c [SLOTS];
    bit              m_v [SLOTS];
    bit              e_done, e_err, e_rv;
    bit [OP_W-1:0]   e_n, e_d, e_c;

    logic [WORD_W-1:0] ws [NW];

    task automatic check(input string nm, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_cnt = 0; m_slot = 0;
        e_done = 0; e_err = 0; e_rv = 0; e_n = '0; e_d = '0; e_c = '0;
        for (int i = 0; i < SLOTS; i++) begin
            m_n[i] = '0; m_d[i] = '0; m_c[i] = '0; m_v[i] = 0;
        end
    endtask

    function automatic bit [OP_W-1:0] pack_op(input int op);
        bit [OP_W-1:0] r = '0;
        for (int i = 0; i < WORDS; i++) r[i*WORD_W +: WORD_W] = m_w[op*WORDS + i];
        return r;
    endfunction

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || zeroize) begin
                model_clear();
            end else begin
                int rs;
                rs = int'(bus.rd_slot);
                e_rv = m_v[rs];
                e_n = m_v[rs] ? m_n[rs] : '0;
                e_d = m_v[rs] ? m_d[rs] : '0;
                e_c = m_v[rs] ? m_c[rs] : '0;
                e_err = bus.ld_start && m_busy;
                e_done = 0;
                if (!m_busy) begin
                    if (bus.ld_start) begin
                        m_busy = 1; m_cnt = 0; m_slot = int'(bus.ld_slot); m_v[m_slot] = 0;
                    end
                end else if (m_cnt == NW) begin
                    m_n[m_slot] = pack_op(0);
                    m_d[m_slot] = pack_op(1);
                    m_c[m_slot] = pack_op(2);
                    m_v[m_slot] = 1; e_done = 1; m_busy = 0;
                end else if (bus.ld_valid) begin
                    m_w[m_cnt] = bus.ld_data;
                    m_cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.ld_done === 1'b1) done_cnt++;
            if (bus.err === 1'b1) err_cnt++;
            if (bus.ld_valid === 1'b1 && bus.ld_ready === 1'b1) xfer_cnt++;
            check("ld_ready", OP_W'(bus.ld_ready), OP_W'(m_busy && m_cnt < NW));
            check("ld_busy", OP_W'(bus.ld_busy), OP_W'(m_busy));
            check("ld_done", OP_W'(bus.ld_done), OP_W'(e_done));
            check("err", OP_W'(bus.err), OP_W'(e_err));
            check("rd_valid", OP_W'(bus.rd_valid), OP_W'(e_rv));
            check("primeNum", bus.primeNum, e_n);
            check("privateKey", bus.privateKey, e_d);
            check("cipher", bus.cipher, e_c);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: still running at %0t, limit 1000000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_ready"}, OP_W'(bus.ld_ready), '0);
        check({nm, "_busy"}, OP_W'(bus.ld_busy), '0);
        check({nm, "_done"}, OP_W'(bus.ld_done), '0);
        check({nm, "_err"}, OP_W'(bus.err), '0);
        check({nm, "_rd_valid"}, OP_W'(bus.rd_valid), '0);
        check({nm, "_n"}, bus.primeNum, '0);
        check({nm, "_d"}, bus.privateKey, '0);
        check({nm, "_c"}, bus.cipher, '0);
    endtask

    // Assert reset a few ns after an edge and confirm outputs clear before the next edge.
    task automatic reset_mid();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_load(input int slot, input int stall_at, input int stall_len,
                           input int err_at, input bit watch);
        int d0, x0;
        d0 = done_cnt;
        x0 = xfer_cnt;
        bus.ld_start = 1'b1;
        bus.ld_slot = SW'(slot);
        bus.ld_valid = 1'b0;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (i == stall_at) begin
                bus.ld_valid = 1'b0;
                repeat (stall_len) tick();
            end
            bus.ld_valid = 1'b1;
            bus.ld_data = ws[i];
            if (i == err_at) begin
                bus.ld_start = 1'b1;
                bus.ld_slot = SW'((slot + 1) % SLOTS);
            end
            tick();
            bus.ld_start = 1'b0;
        end
        // Valid held high through COMMIT must be ignored.
        bus.ld_data = 32'hBAD0BAD0;
        tick();
        bus.ld_valid = 1'b0;
        if (watch) begin
            check("done_after_commit", OP_W'(bus.ld_done), OP_W'(1));
            check("rd_zero_at_commit", OP_W'(bus.rd_valid), '0);
            check("n_zero_at_commit", bus.primeNum, '0);
        end
        repeat (3) tick();
        check("ld_done_count", OP_W'(done_cnt - d0), OP_W'(1));
        check("xfer_count", OP_W'(xfer_cnt - x0), OP_W'(NW));
    endtask

    task automatic read_expect(input int slot, input logic [OP_W-1:0] n, input logic [OP_W-1:0] d,
                               input logic [OP_W-1:0] c);
        bus.rd_slot = SW'(slot);
        tick();
        tick();
        check("lit_rd_valid", OP_W'(bus.rd_valid), OP_W'(1));
        check("lit_primeNum", bus.primeNum, n);
        check("lit_privateKey", bus.privateKey, d);
        check("lit_cipher", bus.cipher, c);
    endtask

    task automatic abort_check(input int d0, input int e0);
        repeat (4) tick();
        check("abort_no_done", OP_W'(done_cnt - d0), '0);
        check("abort_no_err", OP_W'(err_cnt - e0), '0);
        for (int s = 0; s < SLOTS; s++) begin
            bus.rd_slot = SW'(s);
            tick();
            tick();
            check("abort_rd_valid", OP_W'(bus.rd_valid), '0);
            check("abort_primeNum", bus.primeNum, '0);
        end
    endtask

    initial begin
        int d0, e0;
        bus.ld_start = 1'b0;
        bus.ld_slot = '0;
        bus.ld_valid = 1'b0;
        bus.ld_data = '0;
        bus.rd_slot = '0;
        tick();
        tick();
        check_all_zero("in_reset");
        rst_n = 1'b1;
        tick();

        // Basic load into slot 1.
        ws[0] = 32'hFFFFFFFF; ws[1] = 32'h00000000;
        ws[2] = 32'h12345678; ws[3] = 32'h9ABCDEF0;
        ws[4] = 32'h00000001; ws[5] = 32'h00000000;
        do_load(1, -1, 0, -1, 1'b0);
        read_expect(1, 64'h00000000FFFFFFFF, 64'h9ABCDEF012345678, 64'h0000000000000001);

        // Stall of 5 cycles after three words, into slot 2.
        do_load(2, 3, 5, -1, 1'b0);
        read_expect(2, 64'h00000000FFFFFFFF, 64'h9ABCDEF012345678, 64'h0000000000000001);

        // Stray ld_start while loading d, into slot 3.
        e0 = err_cnt;
        do_load(3, -1, 0, 2, 1'b0);
        check("err_pulse_count", OP_W'(err_cnt - e0), OP_W'(1));
        read_expect(3, 64'h00000000FFFFFFFF, 64'h9ABCDEF012345678, 64'h0000000000000001);

        // Reload slot 1 while it is being read.
        bus.rd_slot = SW'(1);
        tick();
        ws[0] = 32'hCAFEBABE; ws[1] = 32'h00C0FFEE;
        ws[2] = 32'hDEADBEEF; ws[3] = 32'h01234567;
        ws[4] = 32'h89ABCDEF; ws[5] = 32'h76543210;
        do_load(1, 2, 3, -1, 1'b1);
        read_expect(1, 64'h00C0FFEECAFEBABE, 64'h01234567DEADBEEF, 64'h7654321089ABCDEF);

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            bus.ld_start = ($urandom_range(0, 5) == 0);
            bus.ld_slot = SW'($urandom_range(0, SLOTS - 1));
            bus.ld_valid = ($urandom_range(0, 3) != 0);
            bus.ld_data = $urandom;
            bus.rd_slot = SW'($urandom_range(0, SLOTS - 1));
            tick();
        end
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        repeat (NW + 4) tick();
        bus.ld_valid = 1'b0;
        tick();

`ifdef RSA_KEY_BANK_ZEROIZE_EN
        d0 = done_cnt;
        e0 = err_cnt;
        bus.ld_start = 1'b1;
        bus.ld_slot = SW'(2);
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        repeat (4) tick();
        bus.ld_valid = 1'b0;
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        abort_check(d0, e0);
        do_load(0, -1, 0, -1, 1'b0);
`endif

        // Reset after four words of a load into slot 0.
        d0 = done_cnt;
        e0 = err_cnt;
        bus.ld_start = 1'b1;
        bus.ld_slot = SW'(0);
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        repeat (4) tick();
        bus.ld_valid = 1'b0;
        reset_mid();
        abort_check(d0, e0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rsa_key_bank.md
RSA_KEY_BANK -- requirements
Module: rsa_key_bank

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning load-bus word width in bits.
REQ-002 The block SHALL have parameter WORDS, default 2, meaning words per operand, so operand width OP_W = WORD_W*WORDS.
REQ-003 The block SHALL have parameter SLOTS, default 4, meaning number of stored key sets (power of 2, at least 2), with SW = $clog2(SLOTS).
REQ-004 The block SHALL have port clk, input, width 1, the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have port ld_start, input, width 1, a start-load pulse.
REQ-007 The block SHALL have port ld_slot, input, width SW, the target slot, sampled with ld_start.
REQ-008 The block SHALL have port ld_valid, input, width 1, meaning ld_data is valid.
REQ-009 The block SHALL have port ld_data, input, width WORD_W, the operand word, least-significant word first.
REQ-010 The block SHALL have port ld_ready, output, width 1, meaning the block accepts a word.
REQ-011 The block SHALL have port ld_busy, output, width 1, meaning a load is in progress.
REQ-012 The block SHALL have port ld_done, output, width 1, a one-cycle pulse on commit.
REQ-013 The block SHALL have port err, output, width 1, a one-cycle pulse on protocol violation.
REQ-014 The block SHALL have port rd_slot, input, width SW, the slot to present.
REQ-015 The block SHALL have port rd_valid, output, width 1, meaning the presented slot holds a committed set.
REQ-016 The block SHALL have ports primeNum, privateKey and cipher, each an output of width OP_W, carrying the stored n, d and c.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD_N, LOAD_D, LOAD_C and COMMIT.
REQ-018 In IDLE, ld_start=1 SHALL latch ld_slot, clear that slot's valid bit, zero the shadow registers and word counter, and move the FSM to LOAD_N at the same edge.
REQ-019 ld_ready SHALL be 1 exactly in LOAD_N, LOAD_D and LOAD_C, and ld_busy SHALL be 1 in every state except IDLE.
REQ-020 A word SHALL transfer only on a rising edge where ld_valid=1 and ld_ready=1, writing shadow word[cnt] of the current operand and incrementing cnt.
REQ-021 When ld_valid=0, the FSM SHALL stall indefinitely with no timeout.
REQ-022 On transfer of word WORDS-1, cnt SHALL wrap to 0 and the FSM SHALL advance LOAD_N->LOAD_D->LOAD_C->COMMIT.
REQ-023 A full load SHALL be exactly 3*WORDS transfers.
REQ-024 COMMIT SHALL last one cycle: at its exit edge all three shadows are written atomically to the latched slot, that slot's valid bit is set, ld_done is 1 for exactly the next cycle, and the FSM returns to IDLE.
REQ-025 ld_start while not IDLE SHALL be ignored (load continues unaffected) and SHALL pulse err for one cycle.
REQ-026 ld_valid=1 while in IDLE or COMMIT SHALL be ignored without err.
REQ-027 Read outputs SHALL be registered with one-cycle latency: at every edge, primeNum, privateKey, cipher and rd_valid are loaded from storage[rd_slot] as it stood before that edge.
REQ-028 If the addressed slot is invalid, the read outputs SHALL load all zeros and rd_valid=0.
REQ-029 Reading the slot under load SHALL return zeros from the edge after ld_start until commit, so partial data is never visible.
REQ-030 When the commit edge coincides with rd_slot equal to the committed slot, the outputs SHALL show pre-commit contents (zeros) for one cycle and the committed values from the following edge.
REQ-031 Other slots SHALL remain readable and unchanged throughout a load.

Reset
REQ-032 Assertion of rst_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE, clear cnt, shadows, all storage and valid bits, and drive ld_ready, ld_busy, ld_done, err, rd_valid, primeNum, privateKey and cipher to 0.
REQ-033 Reset mid-load SHALL discard the load with no commit and no ld_done.
REQ-034 Deassertion of reset SHALL be synchronised by the integrator, and the block SHALL leave IDLE only on the first ld_start after deassertion.

Configuration
REQ-035 When macro RSA_KEY_BANK_ZEROIZE_EN is defined, the block SHALL add input zeroize (width 1), which is synchronous and has priority over all other activity.
REQ-036 With RSA_KEY_BANK_ZEROIZE_EN defined, zeroize=1 at an edge SHALL abort any load to IDLE and clear all state and outputs as reset does, with no ld_done or err pulse.
REQ-037 Without RSA_KEY_BANK_ZEROIZE_EN, the zeroize port SHALL be absent and key material SHALL be cleared only by reset.

Verification
REQ-038 Reset check: rst_n=0 asserted mid-cycle -> all outputs read 0 before the next clk edge and ld_ready=0.
REQ-039 Basic load: load slot 1 with n words FFFFFFFF,00000000, d words 12345678,9ABCDEF0 and c words 00000001,00000000, then rd_slot=1 -> primeNum=64'h00000000FFFFFFFF, privateKey=64'h9ABCDEF012345678, cipher=64'h0000000000000001, rd_valid=1, and ld_done pulses once.
REQ-040 Stall: ld_valid dropped for 5 cycles after word 3 -> no transfer during the gap, the final values match the basic-load case, and the total is 6 transfers.
REQ-041 Protocol error: ld_start during LOAD_D -> err is 1 for exactly one cycle and the slot commits the original data.
REQ-042 Read during load: rd_slot=1, reload slot 1 with new values -> outputs read 0 and rd_valid=0 during the load, old values never reappear, and the new values appear one cycle after the commit edge.
REQ-043 Abort: rst_n pulsed low (or zeroize=1 with RSA_KEY_BANK_ZEROIZE_EN defined) after word 4 -> no ld_done, all slots invalid, and all outputs 0.
